// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared helpers for the pooling stages: counter-width sizing and a
// sign-aware "is b greater than a" compare on pre-extended operands.
package maxpool_2x2_stream_pkg;

    localparam int MAX_DW = 64;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands must already be sign- or zero-extended to MAX_DW bits.
    function automatic logic greater(input logic [MAX_DW-1:0] a,
                                     input logic [MAX_DW-1:0] b,
                                     input logic              sgn);
        if (sgn) begin
            return $signed(b) > $signed(a);
        end else begin
            return b > a;
        end
    endfunction

endpackage

// File: rtl/maxpool_2x2_stream_pool_line_buffer.sv
// Half-width row store for horizontal maxima of the even row of each window pair.
// One write port, one combinational read port; no reset so it maps to distributed RAM.
module pool_line_buffer #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool for one conv output channel, raster-order input.
// Odd trailing column/row are consumed but produce nothing.
module maxpool_2x2_stream
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int IMG_Width  = 4,
    parameter int IMG_Height = 4,
    parameter int Datawidth  = 32,
    parameter int Signed     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In,
    output logic [Datawidth-1:0] Out,
    output logic                 valid_out,
    output logic                 frame_done
);

    localparam int PW = IMG_Width / 2;
    localparam int PH = IMG_Height / 2;
    localparam int CW = cnt_w(IMG_Width);
    localparam int RW = cnt_w(IMG_Height);
    localparam int LD = (PW > 0) ? PW : 1;
    localparam int AW = cnt_w(LD);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_Height - 1);
    localparam logic [CW:0]   COL_END   = (CW+1)'(2 * PW);
    localparam logic [RW:0]   ROW_END   = (RW+1)'(2 * PH);
    localparam logic [CW-1:0] COL_PLAST = CW'(2 * PW - 1);
    localparam logic [RW-1:0] ROW_PLAST = RW'(2 * PH - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [Datawidth-1:0] pair_q, pair_d;
    logic [Datawidth-1:0] out_q, out_d;
    logic                 vout_q, vout_d;
    logic                 fd_q, fd_d;

    logic                 lb_we_s;
    logic [AW-1:0]        lb_addr_s;
    logic [Datawidth-1:0] lb_rdata_s;
    logic [Datawidth-1:0] hmax_s;
    logic                 col_ok_s;
    logic                 row_ok_s;

    function automatic logic [Datawidth-1:0] dmax(input logic [Datawidth-1:0] a,
                                                  input logic [Datawidth-1:0] b);
        logic [MAX_DW-1:0] ea;
        logic [MAX_DW-1:0] eb;
        if (Signed != 0) begin
            ea = MAX_DW'($signed(a));
            eb = MAX_DW'($signed(b));
        end else begin
            ea = MAX_DW'(a);
            eb = MAX_DW'(b);
        end
        return greater(ea, eb, Signed != 0) ? b : a;
    endfunction

    assign lb_addr_s = AW'(col_q >> 1);
    assign hmax_s    = dmax(pair_q, In);
    assign col_ok_s  = {1'b0, col_q} < COL_END;
    assign row_ok_s  = {1'b0, row_q} < ROW_END;

    pool_line_buffer #(
        .DEPTH (LD),
        .DW    (Datawidth),
        .AW    (AW)
    ) u_line_buffer (
        .clk_i   (clk),
        .we_i    (lb_we_s),
        .waddr_i (lb_addr_s),
        .wdata_i (hmax_s),
        .raddr_i (lb_addr_s),
        .rdata_o (lb_rdata_s)
    );

    // Next-state: raster counters, pair register, line-buffer write and pooled output
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        out_d   = out_q;
        vout_d  = 1'b0;
        fd_d    = 1'b0;
        lb_we_s = 1'b0;
        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                pair_d = In;
            end else if (col_ok_s) begin
                // Even row parks the horizontal max; odd row closes the window.
                if (!row_q[0]) begin
                    lb_we_s = 1'b1;
                end else if (row_ok_s) begin
                    out_d  = dmax(lb_rdata_s, hmax_s);
                    vout_d = 1'b1;
                    fd_d   = (row_q == ROW_PLAST) && (col_q == COL_PLAST);
                end else begin
                    lb_we_s = 1'b0;
                end
            end else begin
                lb_we_s = 1'b0;
            end
        end else begin
            vout_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            pair_q <= '0;
            out_q  <= '0;
            vout_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            pair_q <= pair_d;
            out_q  <= out_d;
            vout_q <= vout_d;
            fd_q   <= fd_d;
        end
    end

    assign Out        = out_q;
    assign valid_out  = vout_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: three instances (4x4 unsigned, 4x4 signed, 5x5 unsigned)
// checked every cycle against a window model, plus literal pulse lists per scenario.
module tb_maxpool_2x2_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vin;
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic [2:0]  dv;
    logic [2:0]  dfd;

    int n_chk = 0;
    int n_err = 0;

    int mw [3] = '{4, 4, 5};
    int mh [3] = '{4, 4, 5};
    int ms [3] = '{0, 1, 0};

    logic [31:0] got_q [3][$];
    int          fd_cnt [3];
    logic [31:0] fd_val [3];

    always #5 clk = ~clk;

    maxpool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Signed(0)) u_d0 (
        .clk(clk), .rst(rst), .valid_in(vin[0]), .In(din[0]),
        .Out(dout[0]), .valid_out(dv[0]), .frame_done(dfd[0]));
    maxpool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .Signed(1)) u_d1 (
        .clk(clk), .rst(rst), .valid_in(vin[1]), .In(din[1]),
        .Out(dout[1]), .valid_out(dv[1]), .frame_done(dfd[1]));
    maxpool_2x2_stream #(.IMG_Width(5), .IMG_Height(5), .Datawidth(32), .Signed(0)) u_d2 (
        .clk(clk), .rst(rst), .valid_in(vin[2]), .In(din[2]),
        .Out(dout[2]), .valid_out(dv[2]), .frame_done(dfd[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mmax(input logic [31:0] a, input logic [31:0] b, input int sgn);
        if (sgn != 0) return ($signed(a) > $signed(b)) ? a : b;
        return (a > b) ? a : b;
    endfunction

    // Window model: remember the whole frame, close a window when its bottom-right pixel lands
    int          pr [3];
    int          pc [3];
    logic [31:0] pix [3][8][8];
    logic [31:0] e_out [3];
    logic        e_v [3];
    logic        e_fd [3];

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    pr[d] = 0; pc[d] = 0; e_out[d] = 32'd0; e_v[d] = 1'b0; e_fd[d] = 1'b0;
                end else begin
                    e_v[d]  = 1'b0;
                    e_fd[d] = 1'b0;
                    if (vin[d]) begin
                        pix[d][pr[d]][pc[d]] = din[d];
                        if ((pr[d] % 2 == 1) && (pc[d] % 2 == 1) &&
                            (pr[d] < 2 * (mh[d] / 2)) && (pc[d] < 2 * (mw[d] / 2))) begin
                            e_out[d] = mmax(mmax(pix[d][pr[d]-1][pc[d]-1], pix[d][pr[d]-1][pc[d]], ms[d]),
                                            mmax(pix[d][pr[d]][pc[d]-1],   pix[d][pr[d]][pc[d]],   ms[d]), ms[d]);
                            e_v[d]   = 1'b1;
                            e_fd[d]  = (pr[d] == 2 * (mh[d] / 2) - 1) && (pc[d] == 2 * (mw[d] / 2) - 1);
                        end
                        pc[d]++;
                        if (pc[d] == mw[d]) begin
                            pc[d] = 0;
                            pr[d]++;
                            if (pr[d] == mh[d]) pr[d] = 0;
                        end
                    end
                end
            end
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("d%0d valid_out", d), 32'(dv[d]), 32'(e_v[d]));
                    chk($sformatf("d%0d frame_done", d), 32'(dfd[d]), 32'(e_fd[d]));
                    chk($sformatf("d%0d Out", d), dout[d], e_out[d]);
                    if (dv[d]) got_q[d].push_back(dout[d]);
                    if (dfd[d]) begin
                        fd_cnt[d]++;
                        fd_val[d] = dout[d];
                    end
                end
            end
        end
    end

    task automatic beat(input int d, input logic [31:0] v);
        din[d] = v;
        vin[d] = 1'b1;
        @(posedge clk);
        #1;
        vin[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_list(input int d, input string nm, input logic [31:0] e[$],
                              input int efd, input logic [31:0] efdv);
        chk({nm, " pulses"}, 32'(got_q[d].size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            if (i < got_q[d].size()) chk($sformatf("%s out%0d", nm, i), got_q[d][i], e[i]);
        end
        chk({nm, " frame_done count"}, 32'(fd_cnt[d]), 32'(efd));
        if (efd > 0) chk({nm, " frame_done value"}, fd_val[d], efdv);
        got_q[d].delete();
        fd_cnt[d] = 0;
    endtask

    initial begin
        logic [31:0] e[$];
        logic [31:0] v;
        rst = 1'b1;
        vin = 3'b000;
        for (int d = 0; d < 3; d++) begin
            din[d] = 32'd0;
            fd_cnt[d] = 0;
            fd_val[d] = 32'd0;
        end
        idle(3);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset d%0d Out", d), dout[d], 32'd0);
            chk($sformatf("reset d%0d valid_out", d), 32'(dv[d]), 32'd0);
            chk($sformatf("reset d%0d frame_done", d), 32'(dfd[d]), 32'd0);
        end
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 16; i++) beat(0, 32'(i));
        idle(3);
        e = {32'd5, 32'd7, 32'd13, 32'd15};
        check_list(0, "ramp4x4", e, 1, 32'd15);

        for (int i = 0; i < 16; i++) begin
            v = 32'hFFFF_FFF8;
            if (i == 4) v = 32'hFFFF_FFFD;
            if (i == 15) v = 32'hFFFF_FFFF;
            beat(1, v);
        end
        idle(3);
        e = {32'hFFFF_FFFD, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        check_list(1, "signed4x4", e, 1, 32'hFFFF_FFFF);

        for (int i = 0; i < 25; i++) beat(2, 32'(i));
        idle(3);
        e = {32'd6, 32'd8, 32'd16, 32'd18};
        check_list(2, "odd5x5", e, 1, 32'd18);

        for (int i = 0; i < 16; i++) begin
            beat(0, 32'(i));
            idle($urandom_range(0, 3));
        end
        idle(3);
        e = {32'd5, 32'd7, 32'd13, 32'd15};
        check_list(0, "gapped", e, 1, 32'd15);

        for (int i = 0; i < 6; i++) beat(0, 32'(50 + i));
        rst = 1'b1;
        idle(2);
        chk("midframe reset Out", dout[0], 32'd0);
        chk("midframe reset valid_out", 32'(dv[0]), 32'd0);
        rst = 1'b0;
        got_q[0].delete();
        fd_cnt[0] = 0;
        idle(2);
        for (int i = 0; i < 16; i++) beat(0, 32'(100 + i));
        idle(3);
        e = {32'd105, 32'd107, 32'd113, 32'd115};
        check_list(0, "after reset", e, 1, 32'd115);

        for (int i = 0; i < 16; i++) beat(0, 32'(i));
        for (int i = 0; i < 16; i++) beat(0, 32'(15 - i));
        idle(3);
        e = {32'd5, 32'd7, 32'd13, 32'd15, 32'd15, 32'd13, 32'd7, 32'd5};
        check_list(0, "two frames", e, 2, 32'd5);

        chk("idle d1 pulses", 32'(got_q[1].size()), 32'd0);
        chk("idle d2 pulses", 32'(got_q[2].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
